// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, optional even parity bit when UART_TX_PARITY_EN is defined
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t      state;
  logic [15:0] baud;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        bit_end;
  assign bit_end = baud == LAST;
  // frame sequencer: each state holds its bit for one baud period, outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      baud     <= '0;
      idx      <= '0;
      sh       <= '0;
    end else begin
      tx_done <= 1'b0;
      baud    <= bit_end ? '0 : baud + 16'd1;
      case (state)
        IDLE: begin
          baud <= '0;
          if (tx_valid && tx_ready) begin
            sh       <= tx_data;
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= sh[0];
        end
        DATA: if (bit_end) begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= ^sh;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else
            tx <= sh[idx + 3'd1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          tx_done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at 4 and 2 clocks per bit
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int N  = 4;
  localparam int N2 = 2;
  localparam int FL  = NBITS * N;
  localparam int FL2 = NBITS * N2;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] tx_data, tx_data2;
  logic tx_valid, tx_valid2;
  logic tx_ready, tx, busy, tx_done;
  logic tx_ready2, tx2, busy2, tx_done2;
  int n_checks = 0;
  int n_pass = 0;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );
  uart_tx #(.CLKS_PER_BIT(N2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  function automatic logic fbit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({tx, tx_ready, busy, tx_done} !== 4'b1100) $display("FAIL reset_outs: got %b exp 1100", {tx, tx_ready, busy, tx_done}); else n_pass++;
    n_checks++; if ({tx2, tx_ready2, busy2, tx_done2} !== 4'b1100) $display("FAIL reset_outs2: got %b exp 1100", {tx2, tx_ready2, busy2, tx_done2}); else n_pass++;
    reset = 1'b0; tx_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({tx, tx_ready, busy} !== 3'b110) $display("FAIL reset_priority: got %b exp 110", {tx, tx_ready, busy}); else n_pass++;
  endtask

  task automatic test_frames();
    logic [7:0] vec [2] = '{8'hA5, 8'h01};
    for (int v = 0; v < 2; v++) begin
      logic early = 1'b0;
      @(posedge clk); #1;
      tx_data = vec[v]; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      n_checks++; if ({tx_ready, busy} !== 2'b01) $display("FAIL frame_accept %h: ready,busy=%b exp 01", vec[v], {tx_ready, busy}); else n_pass++;
      for (int k = 0; k < FL; k++) begin
        n_checks++; if (tx !== fbit(vec[v], k / N)) $display("FAIL frame %h cyc%0d: tx=%b exp %b", vec[v], k, tx, fbit(vec[v], k / N)); else n_pass++;
        if (tx_done) early = 1'b1;
        @(posedge clk); #1;
      end
      n_checks++; if ({tx_done, tx_ready, busy, tx, early} !== 5'b11010) $display("FAIL frame_end %h: done,ready,busy,tx,early=%b exp 11010", vec[v], {tx_done, tx_ready, busy, tx, early}); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (tx_done !== 1'b0) $display("FAIL done_pulse %h: tx_done=%b exp 0", vec[v], tx_done); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hAA;
    for (int k = 0; k < FL; k++) begin
      n_checks++; if ({tx, tx_ready} !== {fbit(8'h55, k / N), 1'b0}) $display("FAIL b2b_first cyc%0d: tx,ready=%b exp %b0", k, {tx, tx_ready}, fbit(8'h55, k / N)); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if ({tx, tx_ready, tx_done} !== 3'b111) $display("FAIL b2b_gap: tx,ready,done=%b exp 111", {tx, tx_ready, tx_done}); else n_pass++;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      n_checks++; if ({tx, tx_ready} !== {fbit(8'hAA, k / N), 1'b0}) $display("FAIL b2b_second cyc%0d: tx,ready=%b exp %b0", k, {tx, tx_ready}, fbit(8'hAA, k / N)); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if ({tx, tx_ready, tx_done} !== 3'b111) $display("FAIL b2b_end: tx,ready,done=%b exp 111", {tx, tx_ready, tx_done}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({tx, busy} !== 2'b10) $display("FAIL b2b_no_third: tx,busy=%b exp 10", {tx, busy}); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic bad = 1'b0;
    @(posedge clk); #1;
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < 4 * N + 1; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if ({tx, tx_ready, busy, tx_done} !== 4'b1100) $display("FAIL abort: tx,ready,busy,done=%b exp 1100", {tx, tx_ready, busy, tx_done}); else n_pass++;
    for (int k = 0; k < FL + 8; k++) begin
      if (tx_done || !tx || busy) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL abort_quiet: activity=%b exp 0", bad); else n_pass++;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      n_checks++; if (tx !== fbit(8'h00, k / N)) $display("FAIL after_abort cyc%0d: tx=%b exp %b", k, tx, fbit(8'h00, k / N)); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (tx_done !== 1'b1) $display("FAIL after_abort_done: tx_done=%b exp 1", tx_done); else n_pass++;
  endtask

  task automatic test_data_change();
    @(posedge clk); #1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data = 8'hC3;
    for (int k = 0; k < FL; k++) begin
      n_checks++; if (tx !== fbit(8'h3C, k / N)) $display("FAIL data_change cyc%0d: tx=%b exp %b", k, tx, fbit(8'h3C, k / N)); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (tx_done !== 1'b1) $display("FAIL data_change_done: tx_done=%b exp 1", tx_done); else n_pass++;
  endtask

  task automatic test_min_baud();
    logic early = 1'b0;
    @(posedge clk); #1;
    tx_data2 = 8'h80; tx_valid2 = 1'b1;
    @(posedge clk); #1;
    tx_valid2 = 1'b0;
    for (int k = 0; k < FL2; k++) begin
      n_checks++; if (tx2 !== fbit(8'h80, k / N2)) $display("FAIL min_baud cyc%0d: tx=%b exp %b", k, tx2, fbit(8'h80, k / N2)); else n_pass++;
      if (tx_done2) early = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if ({tx_done2, tx_ready2, busy2, early} !== 4'b1100) $display("FAIL min_baud_end: done,ready,busy,early=%b exp 1100", {tx_done2, tx_ready2, busy2, early}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
    test_min_baud();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tx_data  input  8  byte to transmit, sampled on handshake.
REQ-005 SHALL have port tx_valid  input  1  producer asserts when tx_data is valid.
REQ-006 SHALL have port tx_ready  output  1  high only in IDLE; byte accepted when tx_valid && tx_ready at a rising edge.
REQ-007 SHALL have port tx  output  1  serial line, registered, idle-high.
REQ-008 SHALL have port busy  output  1  high from the accepting edge until the frame's final stop-bit cycle ends.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro-gated), STOP.
REQ-011 SHALL hold tx=1 and tx_ready=1 in IDLE; tx_valid with tx_ready=0 SHALL be ignored, with no queuing.
REQ-012 SHALL, on an accepting edge, latch tx_data into a shift register, enter START, and drive tx=0 from that edge.
REQ-013 SHALL hold every bit on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and clears on each bit change.
REQ-014 SHALL, in DATA, send 8 bits LSB first, using a 3-bit index that wraps 7->0 on exit to the next state.
REQ-015 SHALL, in STOP, drive tx=1 for one bit time, then return to IDLE.
REQ-016 SHALL assert tx_done, tx_ready=1 and busy=0 on the same edge that enters IDLE after STOP; tx_done is high for exactly one cycle.
REQ-017 SHALL make the frame length exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the accepting edge to the IDLE-entry edge.
REQ-018 SHALL allow a new accept no earlier than the IDLE-entry edge plus one cycle, so back-to-back frames are separated by a minimum of one idle cycle at tx=1.
REQ-019 SHALL leave the in-flight frame unaffected by changes to tx_data after the accepting edge.

Reset
REQ-020 SHALL, with reset high at a rising edge, force state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, and clear the baud counter, bit index and shift register.
REQ-021 SHALL let reset mid-frame abort the frame immediately: tx=1 on the next edge, no tx_done, and no partial resumption.
REQ-022 SHALL give reset priority over a simultaneous tx_valid; the byte is not accepted.

Configuration
REQ-023 SHALL use the macro UART_TX_PARITY_EN: when defined, a PARITY state between DATA and STOP sends one even-parity bit (XOR of the 8 data bits).
REQ-024 SHALL, with UART_TX_PARITY_EN undefined, contain no PARITY state or logic, and DATA SHALL go directly to STOP.

Verification
REQ-025 SHALL cover, with CLKS_PER_BIT=4 and no macro: accept 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; tx_done pulses 40 cycles after accept.
REQ-026 SHALL cover, with CLKS_PER_BIT=4 and UART_TX_PARITY_EN defined: accept 0xA5 -> parity bit 0 before stop; tx_done at 44 cycles. Accept 0x01 -> parity bit 1.
REQ-027 SHALL cover: tx_valid held high continuously with 0x55 then 0xAA -> two complete frames, one idle tx=1 cycle between them, and tx_ready low throughout each frame.
REQ-028 SHALL cover: reset asserted during data bit 3 of 0xFF -> tx=1 the next cycle, no tx_done, tx_ready=1; a subsequent 0x00 frame is transmitted correctly.
REQ-029 SHALL cover: tx_data changed from 0x3C to 0xC3 one cycle after accept -> serial data bits still encode 0x3C.
REQ-030 SHALL cover, with CLKS_PER_BIT=2 (minimum): accept 0x80 -> 20-cycle frame, with the final data bit (1) lasting 2 cycles.
